// File: rtl/tx_header_ctrl_pkg.sv
// Shared transmitter types: address pair, header constants and the header controller state set.
package tx_header_ctrl_pkg;

    typedef struct packed {
        logic [47:0] src;
        logic [47:0] dst;
    } address_t;

    localparam logic [15:0] ETHERTYPE_DEFAULT = 16'h88B5;
    localparam int unsigned HDR_LEN           = 14;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        HDR,
        PAYLOAD
    } state_t;

    // Byte idx of {src, dst, ethertype}, MSB byte first; src leads so the
    // received source becomes the transmitted destination (loopback swap).
    function automatic logic [7:0] hdr_byte(input address_t addr,
                                            input logic [15:0] ethertype,
                                            input logic [3:0]  idx);
        logic [111:0] w_hdr;
        w_hdr = {addr.src, addr.dst, ethertype} << {idx, 3'b000};
        return w_hdr[111:104];
    endfunction

endpackage

// File: rtl/tx_header_ctrl_if.sv
// Handshake, address-register and AXI-Stream signals around the header controller.
interface tx_header_ctrl_if;
    import tx_header_ctrl_pkg::*;

    logic       rx_hdr_valid;
    logic       rx_hdr_ready;
    address_t   rx_address;
    logic       address_wr;
    address_t   tx_address;

    logic [7:0] pl_tdata;
    logic       pl_tvalid;
    logic       pl_tlast;
    logic       pl_tready;

    logic [7:0] tx_tdata;
    logic       tx_tvalid;
    logic       tx_tlast;
    logic       tx_tready;

    modport master (
        input  rx_hdr_valid,
        output rx_hdr_ready,
        input  rx_address,
        output address_wr,
        input  tx_address,
        input  pl_tdata,
        input  pl_tvalid,
        input  pl_tlast,
        output pl_tready,
        output tx_tdata,
        output tx_tvalid,
        output tx_tlast,
        input  tx_tready
    );

    modport slave (
        output rx_hdr_valid,
        input  rx_hdr_ready,
        output rx_address,
        input  address_wr,
        output tx_address,
        output pl_tdata,
        output pl_tvalid,
        output pl_tlast,
        input  pl_tready,
        input  tx_tdata,
        input  tx_tvalid,
        input  tx_tlast,
        output tx_tready
    );

endinterface

// File: rtl/tx_header_ctrl.sv
// Prepends a 14-byte Ethernet header (swapped addresses + EtherType) to each payload
// stream, loading the address register once per frame and counting completed frames.
module tx_header_ctrl
    import tx_header_ctrl_pkg::*;
#(
    parameter logic [15:0] ETHERTYPE = ETHERTYPE_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    tx_header_ctrl_if.master   bus,
    output logic [15:0]        frame_cnt
);

    localparam logic [3:0] LAST_IDX = 4'(HDR_LEN - 1);

    state_t      r_state;
    logic [3:0]  r_idx;
    logic [15:0] r_frame_cnt;
    logic        r_address_wr;

    logic        w_pl_end;

    assign w_pl_end  = bus.pl_tvalid && bus.tx_tready && bus.pl_tlast;
    assign frame_cnt = r_frame_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_idx        <= '0;
            r_frame_cnt  <= '0;
            r_address_wr <= 1'b0;
        end else begin
            r_address_wr <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (bus.rx_hdr_valid) begin
                        r_state      <= LOAD;
                        r_address_wr <= 1'b1;
                    end
                end
                LOAD: begin
                    r_state <= HDR;
                end
                HDR: begin
                    if (bus.tx_tready) begin
                        if (r_idx == LAST_IDX) begin
                            r_idx   <= '0;
                            r_state <= PAYLOAD;
                        end else begin
                            r_idx <= r_idx + 4'd1;
                        end
                    end
                end
                PAYLOAD: begin
                    if (w_pl_end) begin
                        r_state     <= IDLE;
                        r_frame_cnt <= r_frame_cnt + 16'd1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Outputs are forced quiet while rst is high, even before the first reset edge lands.
    always_comb begin
        bus.rx_hdr_ready = 1'b0;
        bus.address_wr   = r_address_wr && !rst;
        bus.tx_tdata     = '0;
        bus.tx_tvalid    = 1'b0;
        bus.tx_tlast     = 1'b0;
        bus.pl_tready    = 1'b0;
        if (!rst) begin
            unique case (r_state)
                IDLE: begin
                    bus.rx_hdr_ready = 1'b1;
                end
                HDR: begin
                    bus.tx_tvalid = 1'b1;
                    bus.tx_tdata  = hdr_byte(bus.tx_address, ETHERTYPE, r_idx);
                end
                PAYLOAD: begin
                    bus.tx_tdata  = bus.pl_tdata;
                    bus.tx_tvalid = bus.pl_tvalid;
                    bus.tx_tlast  = bus.pl_tlast;
                    bus.pl_tready = bus.tx_tready;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tx_header_ctrl.sv
// Randomized frame traffic against a byte-queue model of the transmitted stream,
// plus directed frames with literal expectations.
module tb_tx_header_ctrl;
    import tx_header_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] frame_cnt;

    always #5 clk = ~clk;

    tx_header_ctrl_if bus();

    tx_header_ctrl #(.ETHERTYPE(16'h88B5)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .frame_cnt (frame_cnt)
    );

    // Stand-in for tx_address_reg
    always @(posedge clk) begin
        if (rst)                 bus.tx_address <= '0;
        else if (bus.address_wr) bus.tx_address <= bus.rx_address;
    end

    int   tr_mode = 0;
    logic tr_rand = 1'b1;
    logic tr_manual = 1'b1;
    always @(posedge clk) begin
        #1 tr_rand = ($urandom_range(0, 3) != 0);
    end
    assign bus.tx_tready = (tr_mode == 0) ? 1'b1 : (tr_mode == 1) ? tr_rand : tr_manual;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s: timed out at %0t", name, $time);
    endtask

    // Model: expected transmitted beats {last, data} of the current frame
    logic [8:0]   exp_pl[$];
    logic [8:0]   exp_q[$];
    bit           m_active = 0;
    int           m_hs = 0;
    int           m_sent = 0;
    logic [15:0]  m_cnt = '0;
    int           cyc = 0;
    logic         rst_q = 1'b1;
    logic         mon_valid;
    logic         mon_last;
    logic [111:0] mon_h;
    logic [8:0]   mon_p;

    always @(posedge clk) rst_q <= rst;

    always @(negedge clk) begin
        cyc++;
        if (rst_q) begin
            m_active = 0;
            exp_q.delete();
            m_cnt = '0;
        end
        if (rst) begin
            chk("rst_rx_hdr_ready", bus.rx_hdr_ready, 0);
            chk("rst_address_wr", bus.address_wr, 0);
            chk("rst_tx_tvalid", bus.tx_tvalid, 0);
            chk("rst_tx_tlast", bus.tx_tlast, 0);
            chk("rst_tx_tdata", bus.tx_tdata, 0);
            chk("rst_pl_tready", bus.pl_tready, 0);
            if (rst_q) chk("rst_frame_cnt", frame_cnt, 0);
        end else begin
            chk("address_wr", bus.address_wr, 32'(m_active && cyc == m_hs + 1));
            chk("rx_hdr_ready", bus.rx_hdr_ready, 32'(!m_active));
            if (!m_active || cyc < m_hs + 2) mon_valid = 1'b0;
            else if (m_sent < 14)             mon_valid = 1'b1;
            else                              mon_valid = bus.pl_tvalid;
            chk("tx_tvalid", bus.tx_tvalid, 32'(mon_valid));
            if (mon_valid && exp_q.size() > 0) begin
                chk("tx_tdata", bus.tx_tdata, 32'(exp_q[0][7:0]));
                chk("tx_tlast", bus.tx_tlast, 32'(exp_q[0][8]));
            end
            chk("pl_tready", bus.pl_tready,
                32'((m_active && m_sent >= 14 && cyc >= m_hs + 2) ? bus.tx_tready : 1'b0));
            chk("frame_cnt", frame_cnt, 32'(m_cnt));
            if (mon_valid && bus.tx_tready && exp_q.size() > 0) begin
                mon_last = exp_q[0][8];
                void'(exp_q.pop_front());
                m_sent++;
                if (mon_last) begin
                    m_active = 0;
                    m_cnt++;
                end
            end else if (!m_active && bus.rx_hdr_valid) begin
                m_active = 1;
                m_hs     = cyc;
                m_sent   = 0;
                exp_q.delete();
                mon_h = {bus.rx_address.src, bus.rx_address.dst, 16'h88B5};
                for (int i = 0; i < 14; i++) begin
                    exp_q.push_back({1'b0, mon_h[111:104]});
                    mon_h = mon_h << 8;
                end
                while (exp_pl.size() > 0) begin
                    mon_p = exp_pl.pop_front();
                    exp_q.push_back(mon_p);
                    if (mon_p[8]) break;
                end
            end
        end
    end

    logic [7:0] lit [14] = '{8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h0E, 8'h0F,
                             8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h88, 8'hB5};
    logic [7:0] pb [3] = '{8'hAA, 8'hBB, 8'hCC};

    task automatic wait_hs(output bit ok);
        ok = 0;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (bus.rx_hdr_ready) begin
                ok = 1;
                return;
            end
        end
        timeout_fail("handshake");
    endtask

    function automatic address_t rand_addr();
        address_t a;
        a.src = {$urandom(), $urandom()};
        a.dst = {$urandom(), $urandom()};
        return a;
    endfunction

    task automatic send_frame(input address_t a, input int len, input bit gaps, input bit noise);
        logic [7:0] d[$];
        bit ok;
        bit acc;
        for (int i = 0; i < len; i++) begin
            d.push_back(8'($urandom()));
            exp_pl.push_back({(i == len - 1) ? 1'b1 : 1'b0, d[i]});
        end
        @(posedge clk); #1;
        bus.rx_address   = a;
        bus.rx_hdr_valid = 1'b1;
        wait_hs(ok);
        if (!ok) begin
            bus.rx_hdr_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        bus.rx_hdr_valid = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < len; i++) begin
            if (gaps) begin
                for (int g = int'($urandom_range(0, 2)); g > 0; g--) begin
                    bus.pl_tvalid = 1'b0;
                    @(posedge clk); #1;
                end
            end
            if (noise && i < len - 1) begin
                bus.rx_hdr_valid = 1'($urandom_range(0, 1));
                bus.rx_address   = rand_addr();
            end else begin
                bus.rx_hdr_valid = 1'b0;
            end
            bus.pl_tvalid = 1'b1;
            bus.pl_tdata  = d[i];
            bus.pl_tlast  = (i == len - 1);
            acc = 0;
            for (int t = 0; t < 300; t++) begin
                @(negedge clk);
                if (bus.pl_tready) begin
                    acc = 1;
                    break;
                end
            end
            @(posedge clk); #1;
            if (!acc) begin
                timeout_fail("payload_beat");
                break;
            end
        end
        bus.pl_tvalid    = 1'b0;
        bus.pl_tlast     = 1'b0;
        bus.rx_hdr_valid = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        address_t a;
        bit ok;
        bus.rx_hdr_valid = 1'b0;
        bus.rx_address   = '0;
        bus.pl_tdata     = '0;
        bus.pl_tvalid    = 1'b0;
        bus.pl_tlast     = 1'b0;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", bus.rx_hdr_ready, 1);
        chk("cnt_after_rst", frame_cnt, 0);

        // Directed frame: literal header bytes and 3-byte payload
        exp_pl.push_back(9'h0AA);
        exp_pl.push_back(9'h0BB);
        exp_pl.push_back(9'h1CC);
        @(posedge clk); #1;
        bus.rx_address   = {48'h0A0B0C0D0E0F, 48'h112233445566};
        bus.rx_hdr_valid = 1'b1;
        bus.pl_tvalid    = 1'b1;
        bus.pl_tdata     = 8'hAA;
        bus.pl_tlast     = 1'b0;
        @(negedge clk);
        chk("d1_ready", bus.rx_hdr_ready, 1);
        @(posedge clk); #1 bus.rx_hdr_valid = 1'b0;
        @(negedge clk);
        chk("d1_address_wr", bus.address_wr, 1);
        for (int k = 0; k < 14; k++) begin
            @(negedge clk);
            chk("d1_hdr_byte", bus.tx_tdata, 32'(lit[k]));
            chk("d1_hdr_valid", bus.tx_tvalid, 1);
            chk("d1_hdr_last", bus.tx_tlast, 0);
        end
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            chk("d1_pl_byte", bus.tx_tdata, 32'(pb[j]));
            chk("d1_pl_last", bus.tx_tlast, 32'(j == 2));
            @(posedge clk); #1;
            if (j < 2) begin
                bus.pl_tdata = pb[j + 1];
                bus.pl_tlast = (j == 1);
            end else begin
                bus.pl_tvalid = 1'b0;
                bus.pl_tlast  = 1'b0;
            end
        end
        @(negedge clk);
        chk("d1_frame_cnt", frame_cnt, 1);
        chk("d1_ready_after", bus.rx_hdr_ready, 1);

        // Directed frame: 5-cycle backpressure on header byte 7
        tr_manual = 1'b1;
        tr_mode   = 2;
        exp_pl.push_back(9'h15A);
        @(posedge clk); #1;
        bus.rx_hdr_valid = 1'b1;
        bus.pl_tvalid    = 1'b1;
        bus.pl_tdata     = 8'h5A;
        bus.pl_tlast     = 1'b1;
        @(negedge clk);
        @(posedge clk); #1 bus.rx_hdr_valid = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            chk("d2_hdr_byte", bus.tx_tdata, 32'(lit[k]));
        end
        @(posedge clk); #1 tr_manual = 1'b0;
        for (int h = 0; h < 5; h++) begin
            @(negedge clk);
            chk("d2_hold_byte", bus.tx_tdata, 32'h22);
            chk("d2_hold_valid", bus.tx_tvalid, 1);
            @(posedge clk); #1;
            if (h == 4) tr_manual = 1'b1;
        end
        for (int k = 7; k < 14; k++) begin
            @(negedge clk);
            chk("d2_hdr_byte", bus.tx_tdata, 32'(lit[k]));
        end
        @(negedge clk);
        chk("d2_pl_byte", bus.tx_tdata, 32'h5A);
        chk("d2_pl_last", bus.tx_tlast, 1);
        @(posedge clk); #1;
        bus.pl_tvalid = 1'b0;
        bus.pl_tlast  = 1'b0;
        @(negedge clk);
        chk("d2_frame_cnt", frame_cnt, 2);
        tr_mode = 0;

        // Reset while header byte 5 is on the bus
        @(posedge clk); #1;
        bus.rx_address   = rand_addr();
        bus.rx_hdr_valid = 1'b1;
        wait_hs(ok);
        @(posedge clk); #1 bus.rx_hdr_valid = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("d3_hdr_valid", bus.tx_tvalid, 1);
        end
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("d3_tvalid_after_rst", bus.tx_tvalid, 0);
        chk("d3_idle_after_rst", bus.rx_hdr_ready, 1);
        chk("d3_cnt_after_rst", frame_cnt, 0);
        tr_mode = 1;
        send_frame(rand_addr(), 2, 1'b0, 1'b0);
        @(negedge clk);
        chk("d3_cnt_new_frame", frame_cnt, 1);

        // Randomized traffic
        for (int f = 0; f < 30; f++) begin
            send_frame(rand_addr(), int'($urandom_range(1, 6)), 1'b1, 1'b1);
            for (int g = int'($urandom_range(0, 2)); g > 0; g--) @(posedge clk);
        end

        // Counter wrap
        @(posedge clk); #1;
        force dut.r_frame_cnt = 16'hFFFF;
        m_cnt = 16'hFFFF;
        @(posedge clk); #1;
        release dut.r_frame_cnt;
        @(negedge clk);
        chk("wrap_preload", frame_cnt, 32'hFFFF);
        send_frame(rand_addr(), 1, 1'b1, 1'b0);
        @(negedge clk);
        chk("wrap_cnt", frame_cnt, 0);

        repeat (5) @(negedge clk);
        chk("drain_queue", exp_q.size(), 0);
        chk("drain_active", 32'(m_active), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
